// File: rtl/fsm_tx_pkg.sv
// rtl/fsm_tx_pkg.sv - shared state encoding and preamble constants for the sync-word transmitter
package fsm_tx_pkg;

  // Frame phases; 3'b101..3'b111 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    SYNC   = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    DONE   = 3'b100
  } tx_state_t;

  // Default preamble, also used by the 1101 detector benches.
  localparam int         SYNC_LEN_DEF  = 4;
  localparam logic [3:0] SYNC_WORD_DEF = 4'b1101;
  localparam int         DATA_W_DEF    = 8;

  // Counter must reach the longer of the two phase lengths without wrapping.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// rtl/tx_bit_counter.sv - phase bit counter with clear, enable and terminal-count flag
module tx_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Terminal count marks the final bit of the current phase.
  assign tc = (cnt == last);

  // Count up while enabled; holds at the terminal value so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fsm_moore_sync_tx.sv
// rtl/fsm_moore_sync_tx.sv - Moore serial framer: preamble, payload, optional parity (SYNC_TX_PARITY_EN)
module fsm_moore_sync_tx
  import fsm_tx_pkg::*;
#(
  parameter int                  SYNC_LEN  = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(SYNC_WORD_DEF),
  parameter int                  DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_bit,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CW = cnt_width(SYNC_LEN, DATA_W);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_last;
  logic              cnt_tc;
  logic              cnt_clr;
  logic              cnt_en;
  logic              accept;
  logic              sync_bit;
`ifdef SYNC_TX_PARITY_EN
  logic              parity_q;
`endif

  // Words are only taken in IDLE, so in_ready alone gates the handshake.
  assign accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; phase ends are signalled by the shared bit counter.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SYNC;
      SYNC: if (cnt_tc) state_next = DATA;
`ifdef SYNC_TX_PARITY_EN
      DATA:   if (cnt_tc) state_next = PARITY;
      PARITY: state_next = DONE;
`else
      DATA: if (cnt_tc) state_next = DONE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter terminal value depends on the phase being timed.
  always_comb begin
    cnt_last = '0;
    case (state)
      SYNC:    cnt_last = CW'(SYNC_LEN - 1);
      DATA:    cnt_last = CW'(DATA_W - 1);
      default: cnt_last = '0;
    endcase
  end

  // Counter restarts on every state change and only advances in timed phases.
  always_comb begin
    cnt_clr = (state_next != state);
    cnt_en  = (state == SYNC) || (state == DATA);
  end

  tx_bit_counter #(
    .W (CW)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (cnt_last),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  // Payload shift register: load on accept, shift MSB out during DATA.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= in_data;
    end else if (state == DATA) begin
      shreg <= shreg << 1;
    end
  end

`ifdef SYNC_TX_PARITY_EN
  // Even parity of the payload, captured together with the word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^in_data;
    end
  end
`endif

  // Preamble bit select, MSB first as cnt counts up.
  always_comb begin
    sync_bit = 1'b0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      if (cnt == CW'(SYNC_LEN - 1 - i)) sync_bit = SYNC_WORD[i];
    end
  end

  // Moore output decode from state, counter and shift register only.
  always_comb begin
    in_ready = 1'b0;
    out_bit  = 1'b0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      SYNC: begin
        tx_busy = 1'b1;
        out_bit = sync_bit;
      end
      DATA: begin
        tx_busy = 1'b1;
        out_bit = shreg[DATA_W-1];
      end
`ifdef SYNC_TX_PARITY_EN
      PARITY: begin
        tx_busy = 1'b1;
        out_bit = parity_q;
      end
`endif
      DONE:    tx_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_moore_sync_tx.sv
// tb/tb_fsm_moore_sync_tx.sv - directed bench for the sync-word transmitter (SYNC_TX_PARITY_EN aware)
module tb_fsm_moore_sync_tx;

`ifdef SYNC_TX_PARITY_EN
  localparam int FRAME = 14;
`else
  localparam int FRAME = 13;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_bit;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad = 0;

  // Reference 1101 Moore detector fed from the serial line.
  logic [2:0] det_state = 3'd0;
  logic       det;

  fsm_moore_sync_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_bit  (out_bit),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  assign det = (det_state == 3'd4);

  always @(posedge clk) begin
    if (!rst_n) begin
      det_state <= 3'd0;
    end else begin
      case (det_state)
        3'd0:    det_state <= out_bit ? 3'd1 : 3'd0;
        3'd1:    det_state <= out_bit ? 3'd2 : 3'd0;
        3'd2:    det_state <= out_bit ? 3'd2 : 3'd3;
        3'd3:    det_state <= out_bit ? 3'd4 : 3'd0;
        default: det_state <= out_bit ? 3'd2 : 3'd0;
      endcase
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_idle in_ready=%b want=1 after %0d cycles", in_ready, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++;
    if (out_bit !== 1'b0) begin bad++; $display("FAIL reset_out_bit got=%b want=0", out_bit); end
    total++;
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy got=%b want=0", tx_busy); end
    total++;
    if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done got=%b want=0", tx_done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle in_ready=%b tx_busy=%b want 1/0", in_ready, tx_busy);
    end
  endtask

  task automatic test_frame_a5();
    logic [11:0] exp_bits = 12'b1101_1010_0101;
    logic        exp_bit;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL a5_ready_before got=%b want=1", in_ready); end
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'h00;
    for (int i = 1; i <= FRAME; i++) begin
      exp_bit = (i <= 12) ? exp_bits[12-i] : 1'b0;
      total++;
      if (out_bit !== exp_bit) begin
        bad++;
        $display("FAIL a5_out_bit cycle k+%0d got=%b want=%b", i, out_bit, exp_bit);
      end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL a5_in_ready cycle k+%0d got=%b want=0", i, in_ready); end
      total++;
      if (tx_done !== (i == FRAME)) begin
        bad++;
        $display("FAIL a5_tx_done cycle k+%0d got=%b want=%b", i, tx_done, (i == FRAME));
      end
      total++;
      if (tx_busy !== (i < FRAME)) begin
        bad++;
        $display("FAIL a5_tx_busy cycle k+%0d got=%b want=%b", i, tx_busy, (i < FRAME));
      end
      @(negedge clk);
    end
    total++;
    if (in_ready !== 1'b1 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL a5_back_to_idle in_ready=%b tx_done=%b want 1/0", in_ready, tx_done);
    end
  endtask

  task automatic test_back_to_back();
    int         n = 1;
    logic [7:0] pay1 = 8'h00;
    logic [7:0] pay2 = 8'h00;
    in_valid = 1'b1;
    in_data = 8'h3C;
    @(negedge clk);
    in_data = 8'h81;
    while (!in_ready && n < 40) begin
      if (n >= 5 && n <= 12) pay1 = {pay1[6:0], out_bit};
      if (tx_done) begin
        total++;
        if (out_bit !== 1'b0) begin bad++; $display("FAIL b2b_done_out_bit got=%b want=0", out_bit); end
        total++;
        if (n !== FRAME) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=%0d", n, FRAME); end
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== FRAME + 1) begin bad++; $display("FAIL b2b_second_accept got=%0d want=%0d", n, FRAME + 1); end
    total++;
    if (pay1 !== 8'h3C) begin bad++; $display("FAIL b2b_payload1 got=%h want=3c", pay1); end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_start in_ready=%b tx_busy=%b want 0/1", in_ready, tx_busy);
    end
    for (int i = 1; i <= FRAME; i++) begin
      if (i >= 5 && i <= 12) pay2 = {pay2[6:0], out_bit};
      @(negedge clk);
    end
    total++;
    if (pay2 !== 8'h81) begin bad++; $display("FAIL b2b_payload2 got=%h want=81", pay2); end
    wait_idle();
  endtask

  task automatic test_reset_mid_frame();
    int         dones = 0;
    logic [3:0] pre = 4'b0000;
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (out_bit !== 1'b1 || tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_data_bit out_bit=%b tx_busy=%b want 1/1", out_bit, tx_busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (in_ready !== 1'b1 || out_bit !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_idle ready=%b out=%b busy=%b done=%b want 1/0/0/0",
               in_ready, out_bit, tx_busy, tx_done);
    end
    for (int i = 0; i < 20; i++) begin
      if (tx_done === 1'b1) dones++;
      @(negedge clk);
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d want=0", dones); end
    in_valid = 1'b1;
    in_data = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pre = {pre[2:0], out_bit};
      @(negedge clk);
    end
    total++;
    if (pre !== 4'b1101) begin bad++; $display("FAIL rst_mid_preamble got=%b want=1101", pre); end
    wait_idle();
  endtask

  task automatic test_loopback();
    int pulses = 0;
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= FRAME + 2; i++) begin
      if (det === 1'b1) pulses++;
      total++;
      if (det !== (i == 5)) begin
        bad++;
        $display("FAIL loop_det cycle k+%0d got=%b want=%b", i, det, (i == 5));
      end
      @(negedge clk);
    end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL loop_pulses got=%0d want=1", pulses); end
    wait_idle();
  endtask

  task automatic test_ignore_valid();
    logic [7:0] pay = 8'h00;
    int         ready_seen = 0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    @(negedge clk);
    for (int i = 1; i <= FRAME; i++) begin
      if (in_ready !== 1'b0) ready_seen++;
      if (i >= 5 && i <= 12) pay = {pay[6:0], out_bit};
      in_valid = (i < FRAME);
      in_data = 8'($urandom);
      @(negedge clk);
    end
    total++;
    if (ready_seen !== 0) begin bad++; $display("FAIL ign_ready_in_frame got=%0d want=0", ready_seen); end
    total++;
    if (pay !== 8'h5A) begin bad++; $display("FAIL ign_payload got=%h want=5a", pay); end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL ign_no_extra_accept in_ready=%b tx_busy=%b want 1/0", in_ready, tx_busy);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    test_ignore_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
